// File: rtl/mult_funct3_pkg.sv
// Shared multiplier definitions: funct3 encodings, request record, issue FSM states.
// Used by mult_req_fifo and mult_issue_unit.
package mult_funct3_pkg;

  typedef enum logic [2:0] {
    FUNCT3_MUL    = 3'b000,
    FUNCT3_MULH   = 3'b001,
    FUNCT3_MULHSU = 3'b010,
    FUNCT3_MULHU  = 3'b011
  } mult_funct3_t;

  localparam int MULT_FIFO_DEPTH = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP,
    ST_DRAIN
  } issue_state_t;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rd;
  } mult_req_t;

  // mul and mulh produce the same signed x signed 64-bit product.
  function automatic logic [1:0] sign_class(input logic [2:0] op);
    case (op)
      FUNCT3_MULHSU: return 2'd1;
      FUNCT3_MULHU:  return 2'd2;
      default:       return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/mult_issue_unit_fifo.sv
// mult_req_fifo: small request FIFO with flush; pop data is the current head.
// Push and pop are both ignored in a flush cycle, so flush empties it next cycle.
module mult_req_fifo
  import mult_funct3_pkg::*;
#(
  parameter int WIDTH = $bits(mult_req_t),
  parameter int DEPTH = MULT_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W:0] CNT_ONE = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_ONE;
  endfunction

  assign full     = (count == CNT_FULL);
  assign empty    = (count == '0);
  assign do_push  = push && !full && !flush;
  assign do_pop   = pop && !empty && !flush;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mult_issue_unit.sv
// Issues queued multiply requests one at a time to an external multiplier and returns results.
// Optional MULT_PRODUCT_REUSE_EN: reuse the last product when operands and signedness class match.
module mult_issue_unit
  import mult_funct3_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  input  logic [4:0]  req_rd,
  output logic        mul_start,
  output logic [2:0]  mul_op,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic        mul_done,
  input  logic [63:0] mul_product,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [4:0]  resp_rd,
  output logic [31:0] resp_data
);

  issue_state_t state;
  issue_state_t state_next;
  mult_req_t    push_req;
  mult_req_t    head_req;
  logic         fifo_full;
  logic         fifo_empty;
  logic         fifo_pop;
  logic         load_req;
  logic         load_product;
  logic         reuse_hit;
  logic [63:0]  reuse_product;
  logic [2:0]   op_reg;
  logic [31:0]  a_reg;
  logic [31:0]  b_reg;
  logic [4:0]   rd_reg;
  logic [63:0]  product_reg;

  assign push_req  = '{op: req_op, rs1: req_rs1, rs2: req_rs2, rd: req_rd};
  assign req_ready = !fifo_full && (state != ST_DRAIN);

  mult_req_fifo #(
    .WIDTH($bits(mult_req_t)),
    .DEPTH(MULT_FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (req_valid && req_ready),
    .push_data (push_req),
    .pop       (fifo_pop),
    .pop_data  (head_req),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

`ifdef MULT_PRODUCT_REUSE_EN
  logic        reuse_valid;
  logic [31:0] reuse_a;
  logic [31:0] reuse_b;
  logic [1:0]  reuse_class;

  assign reuse_hit = reuse_valid && (head_req.rs1 == reuse_a) && (head_req.rs2 == reuse_b)
                     && (sign_class(head_req.op) == reuse_class);

  // Only products actually delivered to a response are remembered; drained ones are not.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      reuse_valid <= 1'b0;
    end else if (load_product) begin
      reuse_valid   <= 1'b1;
      reuse_a       <= a_reg;
      reuse_b       <= b_reg;
      reuse_class   <= sign_class(op_reg);
      reuse_product <= mul_product;
    end
  end
`else
  assign reuse_hit     = 1'b0;
  assign reuse_product = '0;
`endif

  always_comb begin
    state_next   = state;
    fifo_pop     = 1'b0;
    load_req     = 1'b0;
    load_product = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!flush && !fifo_empty) begin
          fifo_pop   = 1'b1;
          load_req   = 1'b1;
          state_next = reuse_hit ? ST_RESP : ST_ISSUE;
        end
      end
      ST_ISSUE: state_next = flush ? ST_IDLE : ST_WAIT;
      ST_WAIT: begin
        if (flush) begin
          state_next = mul_done ? ST_IDLE : ST_DRAIN;
        end else if (mul_done) begin
          load_product = 1'b1;
          state_next   = ST_RESP;
        end
      end
      ST_RESP:  if (flush || resp_ready) state_next = ST_IDLE;
      ST_DRAIN: if (mul_done) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      op_reg      <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      rd_reg      <= '0;
      product_reg <= '0;
    end else begin
      state <= state_next;
      if (load_req) begin
        op_reg <= head_req.op;
        a_reg  <= head_req.rs1;
        b_reg  <= head_req.rs2;
        rd_reg <= head_req.rd;
      end
      if (load_req && reuse_hit) begin
        product_reg <= reuse_product;
      end else if (load_product) begin
        product_reg <= mul_product;
      end
    end
  end

  // A flush in ISSUE suppresses the start so no orphaned multiply is launched.
  assign mul_start  = (state == ST_ISSUE) && !flush;
  assign mul_op     = op_reg;
  assign mul_a      = a_reg;
  assign mul_b      = b_reg;
  assign resp_valid = (state == ST_RESP);
  assign resp_rd    = rd_reg;
  assign resp_data  = (op_reg == FUNCT3_MUL) ? product_reg[31:0] : product_reg[63:32];

endmodule

// File: tb/tb_mult_issue_unit.sv
// Self-checking bench for mult_issue_unit with a behavioural multiplier and response scoreboard.
module tb_mult_issue_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_rs1;
  logic [31:0] req_rs2;
  logic [4:0]  req_rd;
  logic        mul_start;
  logic [2:0]  mul_op;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic        mul_done;
  logic [63:0] mul_product;
  logic        resp_valid;
  logic        resp_ready;
  logic [4:0]  resp_rd;
  logic [31:0] resp_data;

`ifdef MULT_PRODUCT_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif

  always #5 clk = ~clk;

  mult_issue_unit dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
    .mul_start(mul_start), .mul_op(mul_op), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_product(mul_product),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rd(resp_rd), .resp_data(resp_data)
  );

  typedef struct packed { logic [4:0] rd; logic [31:0] data; } resp_t;
  typedef struct packed { logic [2:0] op; logic [31:0] a; logic [31:0] b; } iss_t;
  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rd;
    logic [31:0] exp;
  } vec_t;

  resp_t sb[$];
  iss_t  iq[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    n_starts = 0;
  int    mul_lat = 2;
  bit    inject_done = 1'b0;
  logic  mul_busy;
  int    mul_cnt;
  logic [63:0] mul_res;

  function automatic logic [63:0] model_product(input logic [2:0] op, input logic [31:0] a,
                                                input logic [31:0] b);
    logic [63:0] ea;
    logic [63:0] eb;
    ea = (op == 3'b011) ? {32'b0, a} : {{32{a[31]}}, a};
    eb = (op == 3'b010 || op == 3'b011) ? {32'b0, b} : {{32{b[31]}}, b};
    return ea * eb;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Behavioural multiplier: done pulses mul_lat cycles after the start cycle.
  always @(posedge clk) begin
    if (rst) begin
      mul_done    <= 1'b0;
      mul_busy    <= 1'b0;
      mul_cnt     <= 0;
      mul_product <= '0;
    end else begin
      mul_done <= 1'b0;
      if (inject_done) begin
        mul_done    <= 1'b1;
        mul_product <= 64'hDEAD_BEEF_0000_0001;
      end else if (mul_start && !mul_busy) begin
        mul_busy <= 1'b1;
        mul_cnt  <= mul_lat - 1;
        mul_res  <= model_product(mul_op, mul_a, mul_b);
      end else if (mul_busy) begin
        if (mul_cnt <= 1) begin
          mul_done    <= 1'b1;
          mul_product <= mul_res;
          mul_busy    <= 1'b0;
        end else begin
          mul_cnt <= mul_cnt - 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && mul_start) begin
      iss_t e;
      n_starts++;
      check("start_while_busy", mul_busy, 0);
      if (iq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_issue: got op=%0d a=%h b=%h required none", mul_op, mul_a, mul_b);
      end else begin
        e = iq.pop_front();
        check("issue_op", mul_op, e.op);
        check("issue_a", mul_a, e.a);
        check("issue_b", mul_b, e.b);
      end
    end
    if (!rst && resp_valid && resp_ready) begin
      resp_t r;
      $display("tb: resp rd=%0d data=%h", resp_rd, resp_data);
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_resp: got rd=%0d data=%h required none", resp_rd, resp_data);
      end else begin
        r = sb.pop_front();
        check("resp_rd", resp_rd, r.rd);
        check("resp_data", resp_data, r.data);
      end
    end
  end

  task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] rd, input logic [31:0] exp, input bit exp_issue,
                      input bit exp_resp);
    int guard;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_op    = op;
    req_rs1   = a;
    req_rs2   = b;
    req_rd    = rd;
    guard     = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!req_ready && guard < 200);
    if (!req_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout rd=%0d: got req_ready=0 required 1", rd);
    end else begin
      if (exp_issue) iq.push_back({op, a, b});
      if (exp_resp)  sb.push_back({rd, exp});
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_start();
    int guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!mul_start && guard < 50);
    check("wait_mul_start", mul_start, 1);
  endtask

  task automatic wait_resp();
    int guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!resp_valid && guard < 50);
    check("wait_resp_valid", resp_valid, 1);
  endtask

  task automatic wait_idle();
    int guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while ((sb.size() != 0 || iq.size() != 0 || resp_valid || mul_busy) && guard < 400);
    check("drain_pending", sb.size() + iq.size(), 0);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_req_ready"}, req_ready, 1);
    check({tag, "_mul_start"}, mul_start, 0);
    check({tag, "_resp_valid"}, resp_valid, 0);
    check({tag, "_mul_op"}, mul_op, 0);
    check({tag, "_mul_a"}, mul_a, 0);
    check({tag, "_mul_b"}, mul_b, 0);
    check({tag, "_resp_rd"}, resp_rd, 0);
    check({tag, "_resp_data"}, resp_data, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish required finish before 500us");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    int   cnt;
    int   s0;
    bit   seen;

    vecs[0] = '{3'b001, 32'hFFFF_FFF9, 32'd3,         5'd1,  32'hFFFF_FFFF};
    vecs[1] = '{3'b011, 32'd7,         32'hFFFF_FFFD, 5'd2,  32'h0000_0006};
    vecs[2] = '{3'b010, 32'hFFFF_FFFF, 32'd2,         5'd3,  32'hFFFF_FFFF};
    vecs[3] = '{3'b010, 32'd2,         32'hFFFF_FFFF, 5'd4,  32'h0000_0001};
    vecs[4] = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd30, 32'hFFFF_FFFE};
    vecs[5] = '{3'b001, 32'h8000_0000, 32'h8000_0000, 5'd31, 32'h4000_0000};
    vecs[6] = '{3'b000, 32'h1234_5678, 32'h10,        5'd0,  32'h2345_6780};
    vecs[7] = '{3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd17, 32'h0000_0001};

    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_op = '0;
    req_rs1 = '0; req_rs2 = '0; req_rd = '0; resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    reset_checks("rst");

    // mul 7 x -3 with exact cycle timing from an empty FIFO
    send(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 1'b1, 1'b1);
    @(negedge clk); check("lat_n1_start", mul_start, 0);
    @(negedge clk); check("lat_n2_start", mul_start, 1);
    @(negedge clk); check("lat_n3_resp", resp_valid, 0);
    @(negedge clk); check("lat_n4_done", mul_done, 1);
    check("lat_n4_resp", resp_valid, 0);
    @(negedge clk); check("lat_n5_resp", resp_valid, 1);
    wait_idle();

    for (int i = 0; i < 8; i++) begin
      send(vecs[i].op, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].exp, 1'b1, 1'b1);
    end
    wait_idle();

    // flush while stalled in RESP with a queued request and a coincident new one
    @(posedge clk); #1 resp_ready = 1'b0;
    send(3'b000, 32'd3, 32'd5, 5'd8, 32'd15, 1'b1, 1'b0);
    wait_resp();
    send(3'b011, 32'd1, 32'd1, 5'd9, 32'd0, 1'b0, 1'b0);
    @(posedge clk); #1;
    flush = 1'b1; req_valid = 1'b1; req_op = 3'b000; req_rs1 = 32'd4; req_rs2 = 32'd4; req_rd = 5'd10;
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b1;
    s0 = n_starts; seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      seen = seen | resp_valid;
    end
    check("flush_starts", n_starts - s0, 0);
    check("flush_resp_seen", seen, 0);
    check("flush_req_ready", req_ready, 1);

    // three back-to-back mulhu behind a stalled response
    @(posedge clk); #1 resp_ready = 1'b0;
    send(3'b011, 32'hFFFF_0000, 32'h0001_0000, 5'd3, 32'h0000_FFFF, 1'b1, 1'b1);
    wait_resp();
    s0 = n_starts;
    for (int c = 0; c < 5; c++) begin
      check("stall_valid", resp_valid, 1);
      check("stall_data", resp_data, 32'h0000_FFFF);
      check("stall_rd", resp_rd, 3);
      @(negedge clk);
    end
    check("stall_no_start", n_starts - s0, 0);
    @(posedge clk); #1;
    req_valid = 1'b1; req_op = 3'b011; req_rs1 = 32'd7; req_rs2 = 32'hFFFF_FFFD; req_rd = 5'd4;
    @(negedge clk); check("b2b_ready_1", req_ready, 1);
    iq.push_back({3'b011, 32'd7, 32'hFFFF_FFFD}); sb.push_back({5'd4, 32'd6});
    @(posedge clk); #1;
    req_rs1 = 32'h0001_0000; req_rs2 = 32'h0001_0000; req_rd = 5'd6;
    @(negedge clk); check("b2b_ready_2", req_ready, 1);
    iq.push_back({3'b011, 32'h0001_0000, 32'h0001_0000}); sb.push_back({5'd6, 32'd1});
    @(posedge clk); #1;
    req_rs1 = 32'h8000_0000; req_rs2 = 32'h8000_0000; req_rd = 5'd7;
    @(negedge clk); check("b2b_full_ready", req_ready, 0);
    @(posedge clk); #1 resp_ready = 1'b1;
    send(3'b011, 32'h8000_0000, 32'h8000_0000, 5'd7, 32'h4000_0000, 1'b1, 1'b1);
    wait_idle();

    // flush during WAIT enters DRAIN until the multiplier finishes
    mul_lat = 6;
    send(3'b010, 32'd5, 32'd6, 5'd11, 32'd0, 1'b1, 1'b0);
    wait_start();
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    check("drain_req_ready", req_ready, 0);
    seen = 1'b0; cnt = 0;
    while (!mul_done && cnt < 20) begin
      seen = seen | resp_valid;
      @(negedge clk);
      cnt++;
    end
    check("drain_done_seen", mul_done, 1);
    check("drain_resp_seen", seen | resp_valid, 0);
    @(negedge clk);
    check("drain_exit_ready", req_ready, 1);
    mul_lat = 2;
    send(3'b000, 32'h0000_FFFF, 32'h0000_FFFF, 5'd12, 32'hFFFE_0001, 1'b1, 1'b1);
    wait_idle();

    // mulh then mul on identical operands
    s0 = n_starts;
    send(3'b001, 32'h8000_0000, 32'd2, 5'd1, 32'hFFFF_FFFF, 1'b1, 1'b1);
    send(3'b000, 32'h8000_0000, 32'd2, 5'd2, 32'h0000_0000, !REUSE, 1'b1);
    wait_idle();
    check("reuse_starts", n_starts - s0, REUSE ? 1 : 2);

    // reset in WAIT abandons the multiply; a late done is ignored
    mul_lat = 6;
    send(3'b000, 32'd9, 32'd9, 5'd13, 32'd81, 1'b1, 1'b0);
    wait_start();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    reset_checks("mid_rst");
    @(posedge clk); #1 inject_done = 1'b1;
    @(posedge clk); #1 inject_done = 1'b0;
    s0 = n_starts; seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen = seen | resp_valid;
    end
    check("late_done_resp", seen, 0);
    check("late_done_starts", n_starts - s0, 0);
    mul_lat = 2;
    send(3'b011, 32'd3, 32'h8000_0000, 5'd14, 32'h0000_0001, 1'b1, 1'b1);
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
